// File: rtl/tc_timer.sv
// tc_timer: bus-mapped 32-bit down-counter with one-shot / auto-reload modes
// and a maskable expiry interrupt.
module tc_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic        en, auto_rl, im;
    logic        wr_ctrl, wr_preset;
    logic        flag_set, flag_clr_fsm, en_clr;

    assign en      = ctrl_q[0];
    assign auto_rl = (ctrl_q[2:1] == 2'b01);
    assign im      = ctrl_q[3];

    assign wr_ctrl   = we && (addr == 2'b00);
    assign wr_preset = we && (addr == 2'b01);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        en_clr       = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d  = 32'd0;
                    flag_set = 1'b1;
                    state_d  = INT;
                end
            end
            INT: begin
                if (auto_rl) begin
                    state_d      = LOAD;
                    flag_clr_fsm = 1'b1;
                end else begin
                    state_d = IDLE;
                    en_clr  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CPU write overrides the FSM's EN clear when it touches byte 0
    always_comb begin
        ctrl_d = ctrl_q;
        if (en_clr) ctrl_d[0] = 1'b0;
        if (wr_ctrl && byteen[0]) ctrl_d = wdata[3:0];
    end

    always_comb begin
        preset_d = preset_q;
        if (wr_preset) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) preset_d[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Set beats any clear landing on the same edge
    always_comb begin
        flag_d = flag_q;
        if (flag_set)
            flag_d = 1'b1;
        else if (flag_clr_fsm || wr_ctrl || wr_preset)
            flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        case (addr)
            2'b00:   rdata = {28'd0, ctrl_q};
            2'b01:   rdata = preset_q;
            2'b10:   rdata = count_q;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = flag_q & im;

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: expected values queued on stimulus,
// popped and compared when the DUT output is sampled.
module tb_tc_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    tc_timer dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [1:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        addr   = a;
        byteen = be;
        wdata  = d;
        we     = 1'b1;
        @(negedge clk);
        we     = 1'b0;
        byteen = 4'h0;
        wdata  = 32'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input logic [1:0] a, input logic [31:0] e,
                       input string tag);
        exp_t it;
        sb.push_back('{tag, e});
        addr = a;
        #1;
        it = sb.pop_front();
        nchk++;
        assert (rdata === it.exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", it.tag, rdata, it.exp);
        end
    endtask

    task automatic chk_irq(input logic e, input string tag);
        exp_t it;
        sb.push_back('{tag, {31'd0, e}});
        it = sb.pop_front();
        nchk++;
        assert (irq === it.exp[0]) else begin
            nerr++;
            $error("FAIL %s: got %b expected %b", it.tag, irq, it.exp[0]);
        end
    endtask

    initial begin
        reset  = 1'b0;
        addr   = 2'b00;
        we     = 1'b0;
        byteen = 4'h0;
        wdata  = 32'h0;
        step(2);
        chk(2'b00, 32'h0, "rst_ctrl");
        chk(2'b01, 32'h0, "rst_preset");
        chk(2'b10, 32'h0, "rst_count");
        chk_irq(1'b0, "rst_irq");
        reset = 1'b1;
        step(2);

        // one-shot, PRESET=3
        wr(2'b01, 4'hF, 32'd3);
        wr(2'b00, 4'hF, 32'h9);
        step(1);
        step(1);
        chk(2'b10, 32'd3, "os_cnt_k2");
        step(1);
        chk(2'b10, 32'd2, "os_cnt_k3");
        step(1);
        chk(2'b10, 32'd1, "os_cnt_k4");
        chk_irq(1'b0, "os_irq_k4");
        step(1);
        chk(2'b10, 32'd0, "os_cnt_k5");
        chk_irq(1'b1, "os_irq_k5");
        step(1);
        chk(2'b00, 32'h8, "os_ctrl_k6");
        chk_irq(1'b1, "os_irq_k6");
        step(3);
        chk_irq(1'b1, "os_irq_hold");
        chk(2'b10, 32'd0, "os_cnt_hold");

        // acknowledge by CTRL write, then masked byte write
        wr(2'b00, 4'hF, 32'h8);
        chk_irq(1'b0, "ack_irq");
        chk(2'b00, 32'h8, "ack_ctrl");
        wr(2'b00, 4'b0001, 32'hFFFF_FFF0);
        chk(2'b00, 32'h0, "be_ctrl");

        // auto-reload, PRESET=2: period 4
        wr(2'b01, 4'hF, 32'd2);
        wr(2'b00, 4'hF, 32'hB);
        step(1);
        for (int j = 0; j < 12; j++) begin
            logic [31:0] ec;
            logic        ei;
            step(1);
            case (j % 4)
                0:       begin ec = 32'd2; ei = 1'b0; end
                1:       begin ec = 32'd1; ei = 1'b0; end
                2:       begin ec = 32'd0; ei = 1'b1; end
                default: begin ec = 32'd0; ei = 1'b0; end
            endcase
            chk(2'b10, ec, $sformatf("ar_cnt_%0d", j));
            chk_irq(ei, $sformatf("ar_irq_%0d", j));
        end
        wr(2'b00, 4'hF, 32'h0);
        step(3);
        chk_irq(1'b0, "ar_off_irq");

        // PRESET write mid-count does not touch COUNT
        wr(2'b01, 4'hF, 32'h100);
        wr(2'b00, 4'hF, 32'h1);
        step(12);
        chk(2'b10, 32'hF6, "mid_cnt");
        wr(2'b01, 4'hF, 32'd5);
        chk(2'b10, 32'hF5, "mid_preset_wr");
        chk(2'b01, 32'd5, "mid_preset_rd");
        wr(2'b10, 4'hF, 32'hDEAD);
        chk(2'b10, 32'hF4, "count_ro");
        chk(2'b11, 32'h0, "unmapped_rd");
        wr(2'b11, 4'hF, 32'hFFFF_FFFF);
        chk(2'b00, 32'h1, "unmapped_ctrl");
        chk(2'b01, 32'd5, "unmapped_preset");
        wr(2'b01, 4'b0010, 32'hAABB_CCDD);
        chk(2'b01, 32'h0000_CC05, "preset_merge");

        // asynchronous reset mid-count
        reset = 1'b0;
        chk(2'b00, 32'h0, "ar_rst_ctrl");
        chk(2'b01, 32'h0, "ar_rst_preset");
        chk(2'b10, 32'h0, "ar_rst_count");
        chk_irq(1'b0, "ar_rst_irq");
        step(1);
        reset = 1'b1;
        step(5);
        chk(2'b10, 32'h0, "post_rst_cnt");
        chk(2'b00, 32'h0, "post_rst_ctrl");

        // masked expiry: flag sets silently, CTRL write clears it
        wr(2'b01, 4'hF, 32'd2);
        wr(2'b00, 4'hF, 32'h1);
        step(4);
        chk(2'b10, 32'd0, "msk_cnt");
        chk_irq(1'b0, "msk_irq");
        step(2);
        chk(2'b00, 32'h0, "msk_ctrl");
        wr(2'b00, 4'hF, 32'h8);
        chk_irq(1'b0, "msk_unmask_irq");
        step(2);
        chk_irq(1'b0, "msk_unmask_irq2");

        // P=0 expiry lands at edge k+3
        wr(2'b01, 4'hF, 32'd0);
        wr(2'b00, 4'hF, 32'h9);
        step(2);
        chk_irq(1'b0, "p0_irq_k2");
        step(1);
        chk_irq(1'b1, "p0_irq_k3");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/tc_timer.md
TC_TIMER -- requirements
Module: tc_timer

Interface
REQ-001 SHALL have port: clk  input  1  system clock; every state change occurs on its rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-003 SHALL have port: addr  input  2  word select from the system bridge: 00 = CTRL, 01 = PRESET, 10 = COUNT, 11 = unmapped.
REQ-004 SHALL have port: we  input  1  write strobe from the bridge, sampled at the clk rising edge.
REQ-005 SHALL have port: byteen  input  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-006 SHALL have port: wdata  input  32  write data.
REQ-007 SHALL have port: rdata  output  32  combinational read of the register selected by addr.
REQ-008 SHALL have port: irq  output  1  interrupt request, routed to one HWInt bit of the CPU.
REQ-009 SHALL have parameter: none; all widths are fixed.

Function
REQ-010 SHALL hold CTRL[31:0] with fields: bit0 EN (count enable); bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00); bit3 IM (interrupt mask, 1 = enabled). CTRL[31:4] SHALL read as 0 and SHALL ignore writes.
REQ-011 SHALL hold PRESET[31:0] (read/write) and COUNT[31:0] (read-only; writes ignored, no side effect).
REQ-012 SHALL merge register writes per byte: on we=1, each byte with byteen[i]=1 is updated and the other bytes are kept.
REQ-013 SHALL give rdata = CTRL, PRESET or COUNT for addr 00/01/10, and 0 for addr 11; writes to addr 11 SHALL be ignored.
REQ-014 SHALL implement a state machine with states IDLE, LOAD, CNT and INT.
REQ-015 IDLE: SHALL go to LOAD when EN=1; otherwise SHALL stay in IDLE.
REQ-016 LOAD: SHALL set COUNT <= PRESET and go to CNT.
REQ-017 CNT, EN=0: SHALL go to IDLE with COUNT frozen.
REQ-018 CNT, EN=1 and COUNT>1: SHALL set COUNT <= COUNT-1 and stay in CNT.
REQ-019 CNT, EN=1 and COUNT<=1: SHALL set COUNT <= 0, set irq_flag <= 1 and go to INT.
REQ-020 INT, MODE=01: SHALL go to LOAD and clear irq_flag on the same edge, so irq_flag is high for exactly one cycle per period.
REQ-021 INT, any other MODE: SHALL go to IDLE and clear EN; irq_flag SHALL stay set.
REQ-022 SHALL drive irq = irq_flag & IM, with no extra register stage.
REQ-023 SHALL clear irq_flag on any write to CTRL or PRESET that is not in the same cycle as a flag set.
REQ-024 SHALL give the timing: write of EN=1 captured at edge k, PRESET=P with P>=1 → irq rises after edge k+P+2; P=0 and P=1 both give edge k+3.
REQ-025 Simultaneous CPU write and FSM update to CTRL: the CPU write SHALL win for all written bytes, except that an FSM EN-clear (REQ-021) SHALL apply only when byteen[0]=0 or we=0.
REQ-026 Simultaneous flag set (REQ-019) and flag clear (REQ-023): the set SHALL win.
REQ-027 A write to PRESET during CNT SHALL NOT change COUNT; it takes effect at the next LOAD.
REQ-028 Clearing EN during CNT and setting it again SHALL pass through IDLE → LOAD, reloading from PRESET; there is no resume.
REQ-029 COUNT SHALL never wrap below 0.

Reset
REQ-030 While reset=0: CTRL, PRESET, COUNT and irq_flag SHALL be 0, the state SHALL be IDLE, and irq and rdata(addr=00) SHALL be 0.
REQ-031 Reset asserted mid-count SHALL abort immediately; after reset releases, the timer SHALL stay in IDLE until EN is written.

Verification
REQ-032 Scenario: PRESET=3, then CTRL=0x9 (EN, one-shot, IM) at edge k → COUNT reads 3,2,1,0 after edges k+2..k+5; irq=1 from edge k+5 and stays high; CTRL reads 0x8 after edge k+6.
REQ-033 Scenario: PRESET=2, CTRL=0xB (auto-reload, IM) → irq is high for one cycle every 4 cycles; COUNT sequence is 2,1,0,(reload)2,... indefinitely.
REQ-034 Scenario: one-shot irq pending, then write CTRL=0x8 → irq drops after that edge; write byteen=0001, wdata=0xFFFFFFF0 to CTRL → CTRL reads 0x0 (EN=0, MODE=00, IM=0).
REQ-035 Scenario: PRESET=0x100, EN set, then after 10 cycles write PRESET=5 → COUNT keeps decrementing from its current value (not 5); write to COUNT has no effect; addr 11 reads 0.
REQ-036 Scenario: IM=0 with expiry → irq stays 0 while the internal flag sets; then write CTRL with IM=1 → irq stays 0, because the write clears the flag.
REQ-037 Scenario: reset=0 pulse mid-CNT with no clock edge → all registers read 0 and irq=0 immediately; after release, no counting until EN is written.
